ama_riscv_simd_arb: RTL and testbench

- Two-requester arbiter and sequencer for the 2-stage SIMD/multiply unit (MUL/MULH/MULHSU/MULHU/DOT16/DOT8).
- Shares one unit between requester 0 (core EXE) and requester 1 (accelerator/LSU-side sequencer).
- Holds the accumulator operand `c` and tag of each in-flight op, so `c_late` reaches the unit in its second stage.
- Returns results through one registered response port, with backpressure that stalls the unit pipe.

---
 rtl/ama_riscv_simd_arb.sv | 171 +++++++++++++++++
 tb/tb_ama_riscv_simd_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_simd_arb.sv
// ============================================================================
// Module   : ama_riscv_simd_arb
// Purpose  : Two-requester arbiter/sequencer for the 2-stage SIMD/multiply
//            unit; carries c/tag alongside the unit pipe, registered response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ama_riscv_simd_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DOT16  = 3'd4,
    DOT8   = 3'd5
  } simd_arith_op_t;
endpackage

module ama_riscv_simd_arb
  import ama_riscv_simd_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_lock,
  input  simd_arith_op_t       req_op   [2],
  input  logic [31:0]          req_a    [2],
  input  logic [31:0]          req_b    [2],
  input  logic [31:0]          req_c    [2],
  input  logic [TAG_W-1:0]     req_tag  [2],
  output logic                 unit_en,
  output simd_arith_op_t       unit_op,
  output logic [31:0]          unit_a,
  output logic [31:0]          unit_b,
  output logic [31:0]          unit_c_late,
  input  logic [31:0]          unit_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          rsp_data
);

  localparam int unsigned      CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  logic             s1_v_q,   s1_v_d;
  logic             s1_id_q,  s1_id_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [31:0]      s1_c_q,   s1_c_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
  logic [31:0]      rsp_data_q,  rsp_data_d;
  logic             rr_q,        rr_d;
  logic             last_q,      last_d;
  logic             lock_hold_q, lock_hold_d;
  logic [CNT_W-1:0] lock_cnt_q,  lock_cnt_d;

  logic stall, any_v, hs, win, lock_act, lock_keep, lock_yield;

  always_comb begin
    stall      = s1_v_q & rsp_valid_q & ~rsp_ready;
    any_v      = |req_valid;
    hs         = any_v & ~stall & ~rst;
    lock_act   = lock_hold_q & req_valid[last_q];
    lock_keep  = lock_act & (lock_cnt_q < LOCK_MAX_C);
    lock_yield = lock_act & ~lock_keep & req_valid[~last_q];

    if (lock_keep)        win = last_q;
    else if (lock_yield)  win = ~last_q;
    else if (&req_valid)  win = rr_q;
    else                  win = req_valid[1];

    req_ready = 2'b00;
    if (hs) req_ready = win ? 2'b10 : 2'b01;
    unit_en = ~rst & ~stall;

    // Operands follow the winner regardless of stall so rsp_ready never reaches a/b;
    // the unit ignores them while unit_en is low.
    unit_op = MUL;
    unit_a  = 32'd0;
    unit_b  = 32'd0;
    if (any_v & ~rst) begin
      unit_op = req_op[win];
      unit_a  = req_a[win];
      unit_b  = req_b[win];
    end
    unit_c_late = s1_v_q ? s1_c_q : 32'd0;

    s1_v_d   = s1_v_q;
    s1_id_d  = s1_id_q;
    s1_tag_d = s1_tag_q;
    s1_c_d   = s1_c_q;
    if (~stall) begin
      s1_v_d = hs;
      if (hs) begin
        s1_id_d  = win;
        s1_tag_d = req_tag[win];
        s1_c_d   = req_c[win];
      end
    end

    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    if (s1_v_q & ~stall) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_id_q;
      rsp_tag_d   = s1_tag_q;
      rsp_data_d  = unit_p;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    rr_d        = rr_q;
    last_d      = last_q;
    lock_hold_d = lock_hold_q;
    lock_cnt_d  = lock_cnt_q;
    if (hs) begin
      rr_d        = ~win;
      last_d      = win;
      lock_hold_d = req_lock[win];
      lock_cnt_d  = lock_keep ? lock_cnt_q + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_tag_q    <= '0;
      s1_c_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= 32'd0;
      rr_q        <= 1'b0;
      last_q      <= 1'b0;
      lock_hold_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      s1_tag_q    <= s1_tag_d;
      s1_c_q      <= s1_c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      lock_hold_q <= lock_hold_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_simd_arb.sv
// ============================================================================
// Module   : tb_ama_riscv_simd_arb
// Purpose  : Scoreboard bench for ama_riscv_simd_arb with a behavioural
//            2-stage SIMD/multiply unit attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ama_riscv_simd_arb;
  import ama_riscv_simd_pkg::*;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned LOCK_MAX = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, req_lock;
  simd_arith_op_t   req_op  [2];
  logic [31:0]      req_a   [2];
  logic [31:0]      req_b   [2];
  logic [31:0]      req_c   [2];
  logic [TAG_W-1:0] req_tag [2];
  logic             unit_en;
  simd_arith_op_t   unit_op;
  logic [31:0]      unit_a, unit_b, unit_c_late, unit_p;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;

  always #5 clk = ~clk;

  ama_riscv_simd_arb #(.TAG_W(TAG_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_tag(req_tag),
    .unit_en(unit_en), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_c_late(unit_c_late), .unit_p(unit_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  // Behavioural unit: stage 1 registers op/a/b, stage 2 combines with c_late.
  simd_arith_op_t u_op_q;
  logic [31:0]    u_a_q, u_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_op_q <= MUL;
      u_a_q  <= 32'd0;
      u_b_q  <= 32'd0;
    end else if (unit_en) begin
      u_op_q <= unit_op;
      u_a_q  <= unit_a;
      u_b_q  <= unit_b;
    end
  end

  function automatic logic [31:0] unit_fn(simd_arith_op_t op, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] c);
    logic [63:0] p;
    logic [31:0] acc, x, y;
    acc = c;
    case (op)
      MUL:    p = {32'd0, a} * {32'd0, b};
      MULH:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MULHSU: p = {{32{a[31]}}, a} * {32'd0, b};
      MULHU:  p = {32'd0, a} * {32'd0, b};
      DOT16: begin
        p = 64'd0;
        for (int h = 0; h < 2; h++) begin
          x = {{16{a[16*h+15]}}, a[16*h +: 16]};
          y = {{16{b[16*h+15]}}, b[16*h +: 16]};
          acc = acc + x * y;
        end
      end
      default: begin
        p = 64'd0;
        for (int k = 0; k < 4; k++) begin
          x = {{24{a[8*k+7]}}, a[8*k +: 8]};
          y = {{24{b[8*k+7]}}, b[8*k +: 8]};
          acc = acc + x * y;
        end
      end
    endcase
    if (op == MUL) return p[31:0];
    if (op == MULH || op == MULHSU || op == MULHU) return p[63:32];
    return acc;
  endfunction

  always_comb unit_p = unit_fn(u_op_q, u_a_q, u_b_q, unit_c_late);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int unsigned      icyc;
    logic             chk_lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_d [2];
  logic        chk_lat_en;
  int          errors   = 0;
  int          n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id      = (i == 1);
        e.tag     = req_tag[i];
        e.data    = exp_d[i];
        e.icyc    = cyc;
        e.chk_lat = chk_lat_en;
        sb.push_back(e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0h expected no response", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_id",   32'(rsp_id),  32'(e.id));
        check("rsp_tag",  32'(rsp_tag), 32'(e.tag));
        check("rsp_data", rsp_data,     e.data);
        if (e.chk_lat) check("rsp_latency", 32'(cyc) - e.icyc, 32'd2);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      sample();
      adv();
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic set_req(input int i, input simd_arith_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [TAG_W-1:0] tag,
                         input logic [31:0] ed);
    req_op[i]  = op;
    req_a[i]   = a;
    req_b[i]   = b;
    req_c[i]   = c;
    req_tag[i] = tag;
    exp_d[i]   = ed;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    req_lock  = 2'b00;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    check("rst_req_ready", 32'(req_ready),   32'd0);
    check("rst_unit_en",   32'(unit_en),     32'd0);
    check("rst_unit_op",   32'(unit_op),     32'(MUL));
    check("rst_unit_a",    unit_a,           32'd0);
    check("rst_unit_c",    unit_c_late,      32'd0);
    check("rst_rsp_data",  rsp_data,         32'd0);
    adv();
    adv();
    rst = 1'b0;
    sb.delete();
  endtask

  logic [31:0] bp_a   [3];
  logic [31:0] bp_exp [3];
  logic [31:0] held;
  logic [1:0]  rd;
  int          k;

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_lock   = 2'b00;
    rsp_ready  = 1'b1;
    chk_lat_en = 1'b1;
    for (int i = 0; i < 2; i++) set_req(i, MUL, 32'd0, 32'd0, 32'd0, '0, 32'd0);
    bp_a[0] = 32'd2;  bp_a[1] = 32'd3;  bp_a[2] = 32'd4;
    bp_exp[0] = 32'd20; bp_exp[1] = 32'd30; bp_exp[2] = 32'd40;
    #1;
    do_reset();

    // Single MUL from R0: 7 * -3
    set_req(0, MUL, 32'd7, 32'hFFFF_FFFD, 32'd0, 4'd5, 32'hFFFF_FFEB);
    req_valid = 2'b01;
    sample();
    check("t1_ready",  32'(req_ready), 32'd1);
    check("t1_unit_a", unit_a,         32'd7);
    adv();
    req_valid = 2'b00;
    drain();

    // Alternation with both requesters valid every cycle
    do_reset();
    set_req(0, MUL, 32'd3, 32'd4, 32'd0, 4'd0, 32'd12);
    set_req(1, MUL, 32'hFFFF_FFFE, 32'd5, 32'd0, 4'd8, 32'hFFFF_FFF6);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      sample();
      rd = req_ready;
      check("alt_grant", 32'(rd), (t % 2 == 1) ? 32'd2 : 32'd1);
      adv();
      if (rd[0]) req_tag[0] = req_tag[0] + 4'd1;
      if (rd[1]) req_tag[1] = req_tag[1] + 4'd1;
    end
    req_valid = 2'b00;
    drain();

    // Backpressure: three R0 ops, rsp_ready low for 4 cycles from the 3rd cycle
    do_reset();
    chk_lat_en = 1'b0;
    k = 0;
    held = 32'd0;
    for (int t = 0; t < 12; t++) begin
      rsp_ready = !(t >= 2 && t <= 5);
      req_valid = (k < 3) ? 2'b01 : 2'b00;
      if (k < 3) set_req(0, MUL, bp_a[k], 32'd10, 32'd0, 4'(k), bp_exp[k]);
      sample();
      if (t >= 2 && t <= 5) begin
        check("bp_unit_en",   32'(unit_en),   32'd0);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        if (t == 2) held = rsp_data;
        else check("bp_rsp_hold", rsp_data, held);
      end
      if (req_valid[0] && req_ready[0]) k++;
      adv();
    end
    check("bp_all_issued", 32'(k), 32'd3);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    drain();
    chk_lat_en = 1'b1;

    // DOT8 then DOT16 from R1, accumulator aligned to stage 2
    do_reset();
    set_req(1, DOT8, 32'h0102_0304, 32'h0101_0101, 32'd100, 4'd9, 32'd110);
    req_valid = 2'b10;
    sample();
    check("dot_ready", 32'(req_ready), 32'd2);
    adv();
    set_req(1, DOT16, 32'h0002_0003, 32'hFFFF_0005, 32'd1, 4'd10, 32'd14);
    sample();
    check("dot8_c_late", unit_c_late, 32'd100);
    adv();
    req_valid = 2'b00;
    sample();
    check("dot16_c_late", unit_c_late, 32'd1);
    adv();
    drain();

    // Lock burst: R0 holds req_lock, R1 always valid
    do_reset();
    set_req(0, MUL, 32'd6, 32'd7, 32'd0, 4'd1, 32'd42);
    set_req(1, MUL, 32'd2, 32'd2, 32'd0, 4'd2, 32'd4);
    req_valid = 2'b11;
    req_lock  = 2'b01;
    for (int t = 0; t < 20; t++) begin
      sample();
      check("lock_grant", 32'(req_ready), (t % 10 == 9) ? 32'd2 : 32'd1);
      adv();
    end
    req_valid = 2'b00;
    req_lock  = 2'b00;
    drain();

    // Async reset with an op sitting in s1
    do_reset();
    set_req(0, MUL, 32'd5, 32'd5, 32'd0, 4'd3, 32'd25);
    req_valid = 2'b01;
    sample();
    adv();
    rst = 1'b1;
    sb.delete();
    set_req(0, MUL, 32'd9, 32'd9, 32'd0, 4'd4, 32'd81);
    set_req(1, MUL, 32'd1, 32'd1, 32'd0, 4'd7, 32'd1);
    req_valid = 2'b11;
    sample();
    check("ar_rsp_valid",  32'(rsp_valid),   32'd0);
    check("ar_req_ready",  32'(req_ready),   32'd0);
    check("ar_unit_en",    32'(unit_en),     32'd0);
    check("ar_unit_c",     unit_c_late,      32'd0);
    adv();
    sample();
    check("ar_rsp_valid2", 32'(rsp_valid),   32'd0);
    adv();
    rst = 1'b0;
    sample();
    check("ar_rr_reset", 32'(req_ready), 32'd1);
    adv();
    req_valid = 2'b00;
    sample();
    check("ar_no_stale_rsp", 32'(rsp_valid), 32'd0);
    adv();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
